// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the datapath-side request/response signals and the
// RAM-side strobes/status used by mem_arbiter.
//   slave  : arbiter view (takes requests + RAM status, drives loads/waits/strobes)
//   master : datapath + RAM model view (the mirror image)
// Signals: iREN/iaddr/iload/iwait (fetch port), dREN/dWEN/daddr/dstore/dload/dwait
// (data port), halt, ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate (RAM), err.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic [DATA_W-1:0] iload;
  logic              iwait;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic [DATA_W-1:0] dload;
  logic              dwait;
  logic              halt;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic              err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
    output iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
    input  iload, iwait, dload, dwait, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction fetches and data reads/writes onto a
// single-ported, variable-latency RAM and stalls the datapath via iwait/dwait.
// Ports:
//   CLK        rising-edge clock
//   nRST       asynchronous active-low reset
//   bus        mem_arbiter_if.slave (fetch port, data port, halt, RAM side, err)
//   icount, dcount, stallcount  (only with MEM_STATS_EN) saturating counters
// Optional feature macro: MEM_STATS_EN.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.slave bus
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]  icount,
  output logic [31:0]  dcount,
  output logic [31:0]  stallcount
`endif
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DATA  = 2'd1;
  localparam logic [1:0] S_INSTR = 2'd2;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  localparam int            TW      = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);

  logic [1:0]        r_state;
  logic              r_last_data;
  logic [TW-1:0]     r_tmo;
  logic              r_err;
  logic              r_ramREN;
  logic              r_ramWEN;
  logic [ADDR_W-1:0] r_ramaddr;
  logic [DATA_W-1:0] r_ramstore;
  logic [DATA_W-1:0] r_iload;
  logic [DATA_W-1:0] r_dload;

  logic              w_dreq;
  logic              w_ireq;
  logic              w_grant_d;
  logic              w_grant_i;
  logic              w_in_grant;
  logic              w_req_held;
  logic              w_done;
  logic              w_fail;
  logic              w_abort;
  logic              w_ddone;
  logic              w_idone;
  logic [DATA_W-1:0] w_load;

  always_comb begin
    w_dreq     = bus.dREN | bus.dWEN;
    w_ireq     = bus.iREN & ~bus.halt;
    // Both pending: grant whichever port did not complete last.
    w_grant_d  = w_dreq & (~w_ireq | ~r_last_data);
    w_grant_i  = w_ireq & (~w_dreq | r_last_data);
    w_in_grant = (r_state == S_DATA) | (r_state == S_INSTR);
    w_req_held = (r_state == S_DATA) ? w_dreq : bus.iREN;
    // Completion needs the request still present; a dropped request is an abort.
    w_done     = w_in_grant & w_req_held &
                 ((bus.ramstate == RS_ACCESS) | (bus.ramstate == RS_ERROR) | (r_tmo == TMO_LIM));
    w_fail     = w_done & (bus.ramstate != RS_ACCESS);
    w_abort    = w_in_grant & ~w_req_held;
    w_ddone    = w_done & (r_state == S_DATA);
    w_idone    = w_done & (r_state == S_INSTR);
    w_load     = w_fail ? '0 : bus.ramload;
  end

  assign bus.iwait    = ~w_idone;
  assign bus.dwait    = ~w_ddone;
  assign bus.iload    = w_idone ? w_load : r_iload;
  assign bus.dload    = (w_ddone & r_ramREN) ? w_load : r_dload;
  assign bus.ramREN   = r_ramREN;
  assign bus.ramWEN   = r_ramWEN;
  assign bus.ramaddr  = r_ramaddr;
  assign bus.ramstore = r_ramstore;
  assign bus.err      = r_err;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= S_IDLE;
      r_last_data <= 1'b0;
      r_tmo       <= '0;
      r_err       <= 1'b0;
      r_ramREN    <= 1'b0;
      r_ramWEN    <= 1'b0;
      r_ramaddr   <= '0;
      r_ramstore  <= '0;
      r_iload     <= '0;
      r_dload     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          if (w_grant_d) begin
            r_state    <= S_DATA;
            r_ramaddr  <= bus.daddr;
            r_ramstore <= bus.dstore;
            // Write wins when both data strobes are raised together.
            r_ramWEN   <= bus.dWEN;
            r_ramREN   <= bus.dREN & ~bus.dWEN;
            if (bus.dREN & bus.dWEN) r_err <= 1'b1;
          end else if (w_grant_i) begin
            r_state   <= S_INSTR;
            r_ramaddr <= bus.iaddr;
            r_ramREN  <= 1'b1;
            r_ramWEN  <= 1'b0;
          end
        end
        S_DATA, S_INSTR: begin
          if (w_done || w_abort) begin
            r_state  <= S_IDLE;
            r_ramREN <= 1'b0;
            r_ramWEN <= 1'b0;
            r_tmo    <= '0;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
          if (w_done) begin
            r_last_data <= (r_state == S_DATA);
            if (w_fail) r_err <= 1'b1;
          end
          if (w_idone) r_iload <= w_load;
          if (w_ddone && r_ramREN) r_dload <= w_load;
        end
        default: begin
          r_state  <= S_IDLE;
          r_ramREN <= 1'b0;
          r_ramWEN <= 1'b0;
          r_tmo    <= '0;
        end
      endcase
    end
  end

`ifdef MEM_STATS_EN
  logic [31:0] r_icount;
  logic [31:0] r_dcount;
  logic [31:0] r_stallcount;
  logic        w_stall;

  assign w_stall    = (w_dreq & ~w_ddone) | (bus.iREN & ~w_idone);
  assign icount     = r_icount;
  assign dcount     = r_dcount;
  assign stallcount = r_stallcount;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_icount     <= '0;
      r_dcount     <= '0;
      r_stallcount <= '0;
    end else begin
      if (w_idone && (r_icount != '1))     r_icount     <= r_icount + 32'd1;
      if (w_ddone && (r_dcount != '1))     r_dcount     <= r_dcount + 32'd1;
      if (w_stall && (r_stallcount != '1)) r_stallcount <= r_stallcount + 32'd1;
    end
  end
`endif
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder side of the datapath memory interface.
- Accepts instruction-fetch requests and the data read/write requests raised by the decoded MemRead/MemWrite strobes.
- Arbitrates both onto a single-ported RAM with variable latency, and returns load data with per-port wait signals.
- Sits between the single-cycle datapath and the RAM model; holds the datapath stalled until each transfer completes.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, word width in bits.
- TIMEOUT, 255, cycles spent in a grant state without ramstate==ACCESS before the transfer is force-completed with error.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction fetch request.
- iaddr  in  ADDR_W  fetch address.
- iload  out  DATA_W  fetched word.
- iwait  out  1  0 = fetch completes this cycle.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dload  out  DATA_W  read data.
- dwait  out  1  0 = data transfer completes this cycle.
- halt  in  1  datapath halted; block new fetch grants.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async, nRST=0):
  - state=IDLE, last_grant=INSTR, tmo counter=0, err=0.
  - ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0, iwait=dwait=1.
- FSM states: IDLE, DATA, INSTR.
- IDLE arbitration:
  - Data and instr both pending: grant the port not in last_grant (alternating; prevents fetch starvation).
  - Only data pending (dREN|dWEN): go to DATA.
  - Only iREN and halt=0: go to INSTR.
  - iREN with halt=1: never granted.
  - No request: stay in IDLE.
- Grant entry:
  - Register ramaddr (and ramstore for DATA) from the requesting port.
  - Assert ramREN or ramWEN from the port's request. dREN and dWEN both high in the same request: write wins, err set.
- Grant state, each cycle:
  - ramstate==ACCESS: completion cycle. Drop the granted wait (combinational); drive dload/iload = ramload (data reads and fetches). Next state IDLE, last_grant updated, strobes deasserted next edge.
  - ramstate==ERROR: same completion, load value 0, err set.
  - ramstate FREE/BUSY: hold; tmo counter increments.
  - Counter reaches TIMEOUT: complete with load 0, err set.
- Latency: minimum 2 cycles from request to wait low (IDLE grant cycle + ACCESS cycle). Back-to-back requests need 1 extra cycle per transfer (return to IDLE).
- Requester must hold request, addr and data stable until its wait is low.
  - Request dropped mid-grant (abort): return to IDLE next edge, no completion, strobes dropped, err unchanged.
- The non-granted port's wait stays 1 while its request is pending.
- iload/dload hold their last completed values between transfers.
- halt asserted during an INSTR grant: the in-flight fetch completes; further fetches are blocked.
- tmo counter clears on every state change.
- err stays set until reset.

Optional Feature:
- MEM_STATS_EN defined: adds outputs icount, dcount, stallcount (32-bit each, reset 0).
  - icount / dcount: incremented on each fetch / data completion.
  - stallcount: incremented every cycle in which any pending port has wait=1.
  - All three saturate at all-ones.
- Undefined: no counter ports, no counter logic.

Test Plan:
- Single fetch: iREN=1, iaddr=0x40, ramstate ACCESS on 2nd cycle, ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x40; iwait low exactly once; iload=0xDEADBEEF.
- Contention: iREN and dWEN (daddr=0x80, dstore=0x12345678) asserted together after reset (last_grant=INSTR) -> DATA granted first with ramWEN=1, ramstore=0x12345678; fetch follows; a second simultaneous pair grants INSTR first.
- BUSY stretch: DATA read with ramstate BUSY 5 cycles then ACCESS, ramload=0xCAFE0001 -> dwait=1 for 6 cycles, 0 on the 7th; dload=0xCAFE0001.
- Timeout: TIMEOUT=8, ramstate stuck BUSY -> completion after 8 grant cycles; dload=0; err=1 persists.
- Halt: halt=1 with iREN=1 from IDLE -> no ramREN for 20 cycles, iwait=1; a concurrent dREN is still serviced.
- Reset mid-grant: nRST low during a DATA grant -> outputs immediately at reset values; after release, a new request is granted normally.
